// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared LEGv8 definitions used by the fetch stage, and later by decode and
// control.
//   fetch_state_t : run-control states of the fetch unit
//   INSTR_BYTES   : size of one instruction in bytes (sequential PC step)
//   BR_SHIFT      : left shift turning a branch word offset into a byte offset
//   branch_target : PC-relative branch target, modulo 2^64
// -----------------------------------------------------------------------------
package legv8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;
    localparam int unsigned BR_SHIFT    = 32'd2;

    // The shift drops the top two immediate bits; the sum wraps silently.
    function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                  input logic [63:0] word_offset);
        return pc + (word_offset << BR_SHIFT);
    endfunction

endpackage

// File: rtl/legv8_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// legv8_fetch_unit_if
// Control/status bundle between the decoder side and the fetch unit.
//   Inputs to the fetch unit : Start, Stall, Branch, Uncondbranch, Zero,
//                              SignExtImm64
//   Outputs of the fetch unit: PC, PCPlus4, Redirect, FetchValid, Halted,
//                              FetchCount
//   master : the side driving run control and branch decisions
//   slave  : the fetch unit itself
// -----------------------------------------------------------------------------
interface legv8_fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic             Start;
    logic             Stall;
    logic             Branch;
    logic             Uncondbranch;
    logic             Zero;
    logic [63:0]      SignExtImm64;
    logic [63:0]      PC;
    logic [63:0]      PCPlus4;
    logic             Redirect;
    logic             FetchValid;
    logic             Halted;
    logic [CNT_W-1:0] FetchCount;

    modport master (
        output Start, Stall, Branch, Uncondbranch, Zero, SignExtImm64,
        input  PC, PCPlus4, Redirect, FetchValid, Halted, FetchCount
    );

    modport slave (
        input  Start, Stall, Branch, Uncondbranch, Zero, SignExtImm64,
        output PC, PCPlus4, Redirect, FetchValid, Halted, FetchCount
    );
endinterface

// File: rtl/legv8_next_pc.sv
// -----------------------------------------------------------------------------
// legv8_next_pc
// Pure combinational next-PC logic: PC+4 adder, branch-target adder, the
// priority select (B over CBZ over sequential) and the Redirect flag.
//   pc           : current PC
//   active       : fetch is progressing this cycle (RUN and not stalled)
//   branch       : CBZ control from the decoder
//   uncondbranch : B control from the decoder
//   zero         : ALU zero flag
//   sign_ext_imm : sign-extended branch word offset
//   pc_plus4     : pc + 4
//   next_pc      : selected next fetch address
//   redirect     : next_pc is a branch target and fetch is active
//   take_branch  : branch target selected (ungated by active)
// -----------------------------------------------------------------------------
module legv8_next_pc
    import legv8_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        active,
    input  logic        branch,
    input  logic        uncondbranch,
    input  logic        zero,
    input  logic [63:0] sign_ext_imm,
    output logic [63:0] pc_plus4,
    output logic [63:0] next_pc,
    output logic        redirect,
    output logic        take_branch
);

    logic [63:0] target_s;
    logic        take_s;

    assign pc_plus4 = pc + INSTR_BYTES;
    assign target_s = branch_target(pc, sign_ext_imm);

    // Priority select; B and CBZ share one target so their overlap is benign.
    always_comb begin
        take_s  = 1'b0;
        next_pc = pc_plus4;
        if (uncondbranch) begin
            take_s  = 1'b1;
            next_pc = target_s;
        end else if (branch && zero) begin
            take_s  = 1'b1;
            next_pc = target_s;
        end else begin
            take_s  = 1'b0;
            next_pc = pc_plus4;
        end
    end

    assign redirect    = active & take_s;
    assign take_branch = take_s;

endmodule

// File: rtl/legv8_fetch_unit.sv
// -----------------------------------------------------------------------------
// legv8_fetch_unit
// PC register, run-control FSM (IDLE/RUN/HALT) and retired-fetch counter of
// the single-cycle LEGv8 core. PC drives the instruction memory address.
//   CLK   : rising-edge clock
//   Reset : synchronous active-high reset, priority over every other input
//   bus   : legv8_fetch_unit_if slave (run control, branch inputs, PC/status)
// Parameters: RESET_PC (low two bits forced to 0), END_PC (first address past
// the program), CNT_W (FetchCount width; must match the interface).
// -----------------------------------------------------------------------------
module legv8_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] END_PC   = 64'h58,
    parameter int          CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    legv8_fetch_unit_if.slave   bus
);

    localparam logic [63:0]      RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_MAX          = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     state_r;
    logic [63:0]      pc_r;
    logic [CNT_W-1:0] count_r;

    logic             active_s;
    logic [63:0]      pc_plus4_s;
    logic [63:0]      next_pc_s;
    logic             redirect_s;
    logic             take_s;
    logic             halt_s;

    assign active_s = (state_r == RUN) && !bus.Stall;

    legv8_next_pc u_next_pc (
        .pc           (pc_r),
        .active       (active_s),
        .branch       (bus.Branch),
        .uncondbranch (bus.Uncondbranch),
        .zero         (bus.Zero),
        .sign_ext_imm (bus.SignExtImm64),
        .pc_plus4     (pc_plus4_s),
        .next_pc      (next_pc_s),
        .redirect     (redirect_s),
        .take_branch  (take_s)
    );

    // Landing exactly on END_PC always halts; running past it only halts on a
    // sequential step, so a branch beyond the program keeps fetching.
    assign halt_s = (next_pc_s == END_PC) || (!take_s && (next_pc_s >= END_PC));

    // Run-control FSM with PC and fetch-counter registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC_ALIGNED;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Start) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.Stall) begin
                        pc_r <= next_pc_s;
                        if (count_r != CNT_MAX) begin
                            count_r <= count_r + CNT_ONE;
                        end
                        if (halt_s) begin
                            state_r <= HALT;
                        end
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.PC         = pc_r;
    assign bus.PCPlus4    = pc_plus4_s;
    assign bus.Redirect   = redirect_s;
    assign bus.FetchValid = active_s;
    assign bus.Halted     = (state_r == HALT);
    assign bus.FetchCount = count_r;

endmodule
